// File: rtl/interp_pkg.sv
// Shared state, channel and sizing definitions for the DSDAC interpolation
// scheduler and the interpolate32 MAC engine.
package interp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    localparam int PHASES_DEFAULT = 32;
    localparam int DW_DEFAULT     = 16;

endpackage

// File: rtl/interp_tag_pipe.sv
// MAC_LAT-deep {valid, ch} delay line aligned with the engine latency; routes each
// tagged result to the left or right output register one cycle after res_valid_i.
module interp_tag_pipe
    import interp_pkg::*;
#(
    parameter int MAC_LAT = 4,
    parameter int DW      = DW_DEFAULT
) (
    input  logic          ACLK,
    input  logic          ARST,
    input  logic          tag_vld_i,
    input  logic          tag_ch_i,
    input  logic [DW-1:0] res_data_i,
    input  logic          res_valid_i,
    output logic [DW-1:0] l_dout_o,
    output logic          l_dout_valid_o,
    output logic [DW-1:0] r_dout_o,
    output logic          r_dout_valid_o
);

    logic [MAC_LAT-1:0] vld_q;
    logic [MAC_LAT-1:0] ch_q;
    logic [DW-1:0]      l_dout_q;
    logic [DW-1:0]      r_dout_q;
    logic               l_dout_valid_q;
    logic               r_dout_valid_q;
    logic               hit;

    // Results with no live tag (e.g. from a burst aborted by reset) are dropped here.
    assign hit = res_valid_i && vld_q[MAC_LAT-1];

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            vld_q          <= '0;
            ch_q           <= '0;
            l_dout_q       <= '0;
            r_dout_q       <= '0;
            l_dout_valid_q <= 1'b0;
            r_dout_valid_q <= 1'b0;
        end else begin
            vld_q[0] <= tag_vld_i;
            ch_q[0]  <= tag_ch_i;
            for (int i = 1; i < MAC_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                ch_q[i]  <= ch_q[i-1];
            end
            l_dout_valid_q <= hit && (ch_q[MAC_LAT-1] == CH_L);
            r_dout_valid_q <= hit && (ch_q[MAC_LAT-1] == CH_R);
            if (hit && (ch_q[MAC_LAT-1] == CH_L)) begin
                l_dout_q <= res_data_i;
            end
            if (hit && (ch_q[MAC_LAT-1] == CH_R)) begin
                r_dout_q <= res_data_i;
            end
        end
    end

    assign l_dout_o       = l_dout_q;
    assign l_dout_valid_o = l_dout_valid_q;
    assign r_dout_o       = r_dout_q;
    assign r_dout_valid_o = r_dout_valid_q;

endmodule

// File: rtl/interp_mac_scheduler.sv
// Round-robin L/R scheduler for one shared PHASES-phase interpolation MAC: LOAD pulse then
// PHASES-cycle burst, back-to-back when pending. INTERP_SCHED_STATS_EN adds per-channel burst counters.
module interp_mac_scheduler
    import interp_pkg::*;
#(
    parameter int  PHASES  = PHASES_DEFAULT,
    parameter int  MAC_LAT = 4,
    parameter int  DW      = DW_DEFAULT,
    localparam int PW      = $clog2(PHASES)
) (
    input  logic          ACLK,
    input  logic          ARST,
    input  logic [DW-1:0] l_din,
    input  logic          l_valid,
    input  logic [DW-1:0] r_din,
    input  logic          r_valid,
    output logic [DW-1:0] mac_din,
    output logic          mac_load,
    output logic          mac_valid,
    output logic [PW-1:0] mac_phase,
    output logic          mac_ch,
    input  logic [DW-1:0] res_data,
    input  logic          res_valid,
    output logic [DW-1:0] l_dout,
    output logic          l_dout_valid,
    output logic [DW-1:0] r_dout,
    output logic          r_dout_valid,
    output logic          busy,
    output logic [1:0]    ovr,
    input  logic          clr_ovr
`ifdef INTERP_SCHED_STATS_EN
    ,
    output logic [15:0]   cnt_l,
    output logic [15:0]   cnt_r
`endif
);

    state_t        state_q;
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    ovr_q, ovr_d;
    logic [DW-1:0] hold_l_q, hold_r_q;
    logic          rr_q;
    logic          mac_load_q, mac_valid_q, mac_ch_q, busy_q;
    logic [DW-1:0] mac_din_q;
    logic [PW-1:0] phase_q;

    logic          last_phase;
    logic          grant_vld;
    logic          grant_ch;
    logic [1:0]    consume;
    logic [1:0]    cap;

    assign last_phase = (state_q == RUN) && (phase_q == PW'(PHASES - 1));
    assign grant_vld  = ((state_q == IDLE) || last_phase) && (|pend_q);
    assign grant_ch   = (pend_q == 2'b11) ? rr_q : pend_q[1];
    assign consume    = grant_vld ? (grant_ch ? 2'b10 : 2'b01) : 2'b00;
    assign cap        = {r_valid, l_valid};

    // A capture in the consuming cycle becomes the next pending sample, not an overrun.
    assign pend_d = (pend_q & ~consume) | cap;
    assign ovr_d  = (clr_ovr ? 2'b00 : ovr_q) | (cap & pend_q & ~consume);

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            pend_q   <= '0;
            ovr_q    <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            if (l_valid) begin
                hold_l_q <= l_din;
            end
            if (r_valid) begin
                hold_r_q <= r_din;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q     <= IDLE;
            rr_q        <= CH_L;
            mac_load_q  <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_ch_q    <= 1'b0;
            mac_din_q   <= '0;
            phase_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            mac_load_q <= 1'b0;
            case (state_q)
                IDLE: ;
                LOAD: begin
                    state_q     <= RUN;
                    mac_valid_q <= 1'b1;
                end
                RUN: begin
                    if (last_phase) begin
                        state_q     <= IDLE;
                        mac_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        phase_q     <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Grant overrides the RUN exit so a pending channel starts with no idle gap.
            if (grant_vld) begin
                state_q    <= LOAD;
                mac_load_q <= 1'b1;
                busy_q     <= 1'b1;
                mac_ch_q   <= grant_ch;
                mac_din_q  <= grant_ch ? hold_r_q : hold_l_q;
                if (pend_q == 2'b11) begin
                    rr_q <= ~rr_q;
                end
            end
        end
    end

    assign mac_din   = mac_din_q;
    assign mac_load  = mac_load_q;
    assign mac_valid = mac_valid_q;
    assign mac_phase = phase_q;
    assign mac_ch    = mac_ch_q;
    assign busy      = busy_q;
    assign ovr       = ovr_q;

    interp_tag_pipe #(
        .MAC_LAT (MAC_LAT),
        .DW      (DW)
    ) u_tag_pipe (
        .ACLK           (ACLK),
        .ARST           (ARST),
        .tag_vld_i      (mac_valid_q),
        .tag_ch_i       (mac_ch_q),
        .res_data_i     (res_data),
        .res_valid_i    (res_valid),
        .l_dout_o       (l_dout),
        .l_dout_valid_o (l_dout_valid),
        .r_dout_o       (r_dout),
        .r_dout_valid_o (r_dout_valid)
    );

`ifdef INTERP_SCHED_STATS_EN
    logic [15:0] cnt_l_q, cnt_r_q;

    always_ff @(posedge ACLK) begin
        if (ARST || clr_ovr) begin
            cnt_l_q <= '0;
            cnt_r_q <= '0;
        end else if (last_phase) begin
            if ((mac_ch_q == CH_L) && (cnt_l_q != 16'hFFFF)) begin
                cnt_l_q <= cnt_l_q + 16'd1;
            end
            if ((mac_ch_q == CH_R) && (cnt_r_q != 16'hFFFF)) begin
                cnt_r_q <= cnt_r_q + 16'd1;
            end
        end
    end

    assign cnt_l = cnt_l_q;
    assign cnt_r = cnt_r_q;
`endif

endmodule

// File: tb/tb_interp_mac_scheduler.sv
// Directed bench: a per-cycle expected timeline built from burst start cycles, an engine
// model returning phase + ch*0x100 after MAC_LAT cycles, and literal spot checks.
module tb_interp_mac_scheduler;
    import interp_pkg::*;

    localparam int LAT = 4;
    localparam int W   = 16;
    localparam int N   = 1024;

    logic          ACLK = 1'b0;
    logic          ARST = 1'b1;
    logic [W-1:0]  l_din = '0, r_din = '0;
    logic          l_valid = 1'b0, r_valid = 1'b0, clr_ovr = 1'b0;
    logic [W-1:0]  mac_din, l_dout, r_dout;
    logic          mac_load, mac_valid, mac_ch, l_dout_valid, r_dout_valid, busy;
    logic [4:0]    mac_phase;
    logic [1:0]    ovr;
    logic [W-1:0]  res_data = '0;
    logic          res_valid = 1'b0;
`ifdef INTERP_SCHED_STATS_EN
    logic [15:0]   cnt_l, cnt_r;
`endif

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    bit cmp_en = 1'b0;

    bit         exp_load[N], exp_vld[N], exp_busy[N], exp_ldv[N], exp_rdv[N], exp_ch[N];
    bit [W-1:0] exp_din[N], exp_ld[N], exp_rd[N];
    bit [4:0]   exp_ph[N];
    bit         eng_v[N], eng_c[N];
    bit [4:0]   eng_p[N];

    int         busy_seen, ldv_seen, rdv_seen;
    bit [W-1:0] last_l;

    interp_mac_scheduler #(.PHASES(32), .MAC_LAT(LAT), .DW(W)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .l_din(l_din), .l_valid(l_valid), .r_din(r_din), .r_valid(r_valid),
        .mac_din(mac_din), .mac_load(mac_load), .mac_valid(mac_valid),
        .mac_phase(mac_phase), .mac_ch(mac_ch),
        .res_data(res_data), .res_valid(res_valid),
        .l_dout(l_dout), .l_dout_valid(l_dout_valid),
        .r_dout(r_dout), .r_dout_valid(r_dout_valid),
        .busy(busy), .ovr(ovr), .clr_ovr(clr_ovr)
`ifdef INTERP_SCHED_STATS_EN
        , .cnt_l(cnt_l), .cnt_r(cnt_r)
`endif
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, want);
        end
    endtask

    // A sample loaded at cycle c: LOAD at c, phases 0..31 at c+1..c+32,
    // result for phase k back at c+1+k+LAT and on the output one cycle later.
    task automatic add_burst(input int c, input bit ch, input bit [W-1:0] din);
        exp_load[c] = 1'b1;
        exp_busy[c] = 1'b1;
        exp_ch[c]   = ch;
        exp_din[c]  = din;
        for (int k = 0; k < 32; k++) begin
            exp_vld[c+1+k]  = 1'b1;
            exp_busy[c+1+k] = 1'b1;
            exp_ch[c+1+k]   = ch;
            exp_ph[c+1+k]   = 5'(k);
            if (ch == CH_L) begin
                exp_ldv[c+k+LAT+2] = 1'b1;
                exp_ld[c+k+LAT+2]  = W'(k);
            end else begin
                exp_rdv[c+k+LAT+2] = 1'b1;
                exp_rd[c+k+LAT+2]  = W'(16'h0100 + k);
            end
        end
    endtask

    task automatic truncate(input int from);
        for (int t = from; t < N; t++) begin
            exp_load[t] = 1'b0; exp_vld[t] = 1'b0; exp_busy[t] = 1'b0;
            exp_ldv[t]  = 1'b0; exp_rdv[t] = 1'b0; exp_ph[t]   = '0;
        end
    endtask

    task automatic drive(input bit lv, input bit [W-1:0] ld, input bit rv, input bit [W-1:0] rd, input bit clr);
        l_valid = lv; l_din = ld; r_valid = rv; r_din = rd; clr_ovr = clr;
        @(negedge ACLK);
        l_valid = 1'b0; r_valid = 1'b0; clr_ovr = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge ACLK);
    endtask

    // Engine model: echoes phase + ch*0x100 exactly LAT cycles after each mac_valid beat.
    always @(negedge ACLK) begin
        if (cyc < N) begin
            eng_v[cyc] = mac_valid;
            eng_p[cyc] = mac_phase;
            eng_c[cyc] = mac_ch;
            if (cyc >= LAT && eng_v[cyc-LAT]) begin
                res_valid = 1'b1;
                res_data  = W'(eng_p[cyc-LAT]) + (eng_c[cyc-LAT] ? 16'h0100 : 16'h0000);
            end else begin
                res_valid = 1'b0;
                res_data  = 16'hDEAD;
            end
        end
    end

    always @(negedge ACLK) begin
        if (cmp_en && cyc < N) begin
            chk("mac_load",     cyc, 32'(mac_load),     32'(exp_load[cyc]));
            chk("mac_valid",    cyc, 32'(mac_valid),    32'(exp_vld[cyc]));
            chk("busy",         cyc, 32'(busy),         32'(exp_busy[cyc]));
            chk("mac_phase",    cyc, 32'(mac_phase),    32'(exp_ph[cyc]));
            chk("l_dout_valid", cyc, 32'(l_dout_valid), 32'(exp_ldv[cyc]));
            chk("r_dout_valid", cyc, 32'(r_dout_valid), 32'(exp_rdv[cyc]));
            if (exp_load[cyc] || exp_vld[cyc]) chk("mac_ch", cyc, 32'(mac_ch), 32'(exp_ch[cyc]));
            if (exp_load[cyc]) chk("mac_din", cyc, 32'(mac_din), 32'(exp_din[cyc]));
            if (exp_ldv[cyc])  chk("l_dout",  cyc, 32'(l_dout),  32'(exp_ld[cyc]));
            if (exp_rdv[cyc])  chk("r_dout",  cyc, 32'(r_dout),  32'(exp_rd[cyc]));
            busy_seen += int'(busy);
            rdv_seen  += int'(r_dout_valid);
            if (l_dout_valid) begin
                ldv_seen++;
                last_l = l_dout;
            end
        end
    end

    initial begin
        int n;
        idle(3);
        ARST = 1'b0;
        chk("rst_mac_din", cyc, 32'(mac_din), 32'h0);
        chk("rst_mac_ch",  cyc, 32'(mac_ch),  32'h0);
        chk("rst_ovr",     cyc, 32'(ovr),     32'h0);
        chk("rst_l_dout",  cyc, 32'(l_dout),  32'h0);
        busy_seen = 0; ldv_seen = 0; rdv_seen = 0; last_l = '0;
        cmp_en = 1'b1;

        // Single left sample
        n = cyc;
        add_burst(n + 2, CH_L, 16'h1234);
        drive(1'b1, 16'h1234, 1'b0, '0, 1'b0);
        idle(44);
        chk("t1_busy_cycles", cyc, 32'(busy_seen), 32'd33);
        chk("t1_l_pulses",    cyc, 32'(ldv_seen),  32'd32);
        chk("t1_last_l",      cyc, 32'(last_l),    32'h001F);
        chk("t1_r_pulses",    cyc, 32'(rdv_seen),  32'd0);

        // Simultaneous pairs: L then R, then R then L
        n = cyc;
        add_burst(n + 2,  CH_L, 16'hAAAA);
        add_burst(n + 35, CH_R, 16'h5555);
        drive(1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b0);
        idle(74);
        n = cyc;
        add_burst(n + 2,  CH_R, 16'h2222);
        add_burst(n + 35, CH_L, 16'h1111);
        drive(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0);
        idle(74);
        chk("t2_r_pulses", cyc, 32'(rdv_seen), 32'd64);

        // Overrun while L waits behind an R burst; set beats clear
        n = cyc;
        add_burst(n + 2,  CH_R, 16'h0300);
        add_burst(n + 35, CH_L, 16'h0C0E);
        drive(1'b0, '0, 1'b1, 16'h0300, 1'b0);
        drive(1'b1, 16'h0BAD, 1'b0, '0, 1'b0);
        idle(9);
        drive(1'b1, 16'h0C0D, 1'b0, '0, 1'b0);
        chk("t3_ovr_set", cyc, 32'(ovr), 32'h1);
        idle(1);
        drive(1'b1, 16'h0C0E, 1'b0, '0, 1'b1);
        chk("t3_ovr_set_beats_clr", cyc, 32'(ovr), 32'h1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t3_ovr_cleared", cyc, 32'(ovr), 32'h0);
        idle(60);

        // New sample in the consuming cycle is pending, not an overrun
        n = cyc;
        add_burst(n + 2,  CH_L, 16'h0E01);
        add_burst(n + 35, CH_L, 16'h0E02);
        drive(1'b1, 16'h0E01, 1'b0, '0, 1'b0);
        drive(1'b1, 16'h0E02, 1'b0, '0, 1'b0);
        chk("t5_no_ovr", cyc, 32'(ovr), 32'h0);
        idle(73);

        // Reset at RUN phase 10 of an L burst with R also pending
        n = cyc;
        add_burst(n + 2,  CH_L, 16'h0F00);
        add_burst(n + 35, CH_R, 16'h0F11);
        drive(1'b1, 16'h0F00, 1'b1, 16'h0F11, 1'b0);
        idle(12);
        chk("t6_phase_before_rst", cyc, 32'(mac_phase), 32'd10);
        ARST = 1'b1;
        truncate(cyc + 1);
        idle(1);
        ARST = 1'b0;
        chk("t6_rst_mac_valid", cyc, 32'(mac_valid), 32'h0);
        chk("t6_rst_busy",      cyc, 32'(busy),      32'h0);
        chk("t6_rst_mac_din",   cyc, 32'(mac_din),   32'h0);
        chk("t6_rst_mac_ch",    cyc, 32'(mac_ch),    32'h0);
        chk("t6_rst_l_dout",    cyc, 32'(l_dout),    32'h0);
        idle(10);

        // After reset rr starts at L again; three L and two R bursts complete
        n = cyc;
        add_burst(n + 2,  CH_L, 16'h0101);
        add_burst(n + 35, CH_R, 16'h0202);
        drive(1'b1, 16'h0101, 1'b1, 16'h0202, 1'b0);
        idle(74);
        n = cyc;
        add_burst(n + 2, CH_L, 16'h0303);
        drive(1'b1, 16'h0303, 1'b0, '0, 1'b0);
        idle(40);
        n = cyc;
        add_burst(n + 2,  CH_R, 16'h0505);
        add_burst(n + 35, CH_L, 16'h0404);
        drive(1'b1, 16'h0404, 1'b1, 16'h0505, 1'b0);
        idle(74);
`ifdef INTERP_SCHED_STATS_EN
        chk("stats_cnt_l", cyc, 32'(cnt_l), 32'd3);
        chk("stats_cnt_r", cyc, 32'(cnt_r), 32'd2);
`endif
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
